// File: rtl/ray_thread_generator_pkg.sv
// Shared types for the primary-ray thread generator and its consumers.
package ray_thread_generator_pkg;

    // Default frame geometry and ray-core count used by the Surface pipeline.
    localparam int DEFAULT_WIDTH  = 160;
    localparam int DEFAULT_HEIGHT = 120;
    localparam int RAY_CORE_SIZE  = 4;

    localparam int DEFAULT_X_W    = $clog2(DEFAULT_WIDTH);
    localparam int DEFAULT_Y_W    = $clog2(DEFAULT_HEIGHT);
    localparam int DEFAULT_IDX_W  = $clog2(DEFAULT_WIDTH * DEFAULT_HEIGHT);
    localparam int DEFAULT_CORE_W = $clog2(RAY_CORE_SIZE);

    // Thread coordinate bundle at default geometry, shaped so Surface's
    // input_data can absorb it directly.
    typedef struct packed {
        logic [DEFAULT_X_W-1:0]    x;
        logic [DEFAULT_Y_W-1:0]    y;
        logic [DEFAULT_IDX_W-1:0]  pixel_index;
        logic [DEFAULT_CORE_W-1:0] core_id;
    } thread_coord_t;

    // Generator control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RS = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } tg_state_t;

endpackage

// File: rtl/ray_thread_generator_raster.sv
// Raster-order pixel counter: x/y/linear index plus round-robin core id.
// Everything is incremented and compared against the frame bounds; the
// linear index never goes through a multiplier.
module raster_counter
    import ray_thread_generator_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int HEIGHT    = DEFAULT_HEIGHT,
    parameter int CORE_SIZE = RAY_CORE_SIZE,
    parameter int X_W       = $clog2(WIDTH),
    parameter int Y_W       = $clog2(HEIGHT),
    parameter int IDX_W     = $clog2(WIDTH * HEIGHT),
    parameter int CORE_W    = (CORE_SIZE > 1) ? $clog2(CORE_SIZE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [IDX_W-1:0]  pixel_index,
    output logic [CORE_W-1:0] core_id,
    output logic              last_pixel
);

    logic x_last;
    logic y_last;
    logic core_last;

    assign x_last     = (x == X_W'(WIDTH - 1));
    assign y_last     = (y == Y_W'(HEIGHT - 1));
    assign core_last  = (core_id == CORE_W'(CORE_SIZE - 1));
    assign last_pixel = x_last && y_last;

    // Step to the next pixel on advance; the last pixel folds everything
    // back to zero so an idle generator presents a clean origin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            pixel_index <= '0;
            core_id     <= '0;
        end else if (clear) begin
            x           <= '0;
            y           <= '0;
            pixel_index <= '0;
            core_id     <= '0;
        end else if (advance) begin
            if (last_pixel) begin
                x           <= '0;
                y           <= '0;
                pixel_index <= '0;
                core_id     <= '0;
            end else begin
                if (x_last) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
                pixel_index <= pixel_index + 1'b1;
                core_id     <= core_last ? '0 : core_id + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ray_thread_generator.sv
// Primary-ray thread generator: on a frame strobe, waits for RenderState and
// then emits one thread per accepted cycle in raster order.
//
// Handshake: a thread is offered while valid=1 and is consumed on any cycle
// where valid=1 and output_fifo_full=0 (output_fifo_full acts as !ready).
// While full is high the offered thread and all its fields are held stable;
// valid never drops before the offered thread has been consumed.
module ray_thread_generator
    import ray_thread_generator_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int HEIGHT    = DEFAULT_HEIGHT,
    parameter int CORE_SIZE = RAY_CORE_SIZE,
    parameter int X_W       = $clog2(WIDTH),
    parameter int Y_W       = $clog2(HEIGHT),
    parameter int IDX_W     = $clog2(WIDTH * HEIGHT),
    parameter int CORE_W    = (CORE_SIZE > 1) ? $clog2(CORE_SIZE) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              strobe,
    input  logic              rs_valid,
    input  logic              output_fifo_full,
    output logic              valid,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [IDX_W-1:0]  pixel_index,
    output logic [CORE_W-1:0] core_id,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output tg_state_t         dbg_state
);

    tg_state_t state;
    tg_state_t state_next;
    logic      rs_q;
    logic      clear_cnt;
    logic      accept;
    logic      last_pixel;

    // All status outputs are decoded from the registered state only.
    assign valid      = (state == RUN);
    assign busy       = (state == WAIT_RS) || (state == RUN);
    assign frame_done = (state == DONE);
    assign dbg_state  = state;
    assign accept     = valid && !output_fifo_full;

    // RenderState valid is registered so emission starts from a clean flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rs_q <= 1'b0;
        else       rs_q <= rs_valid;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; strobes outside IDLE fall through unused.
    always_comb begin
        state_next = state;
        clear_cnt  = 1'b0;
        case (state)
            IDLE: begin
                if (strobe) begin
                    state_next = WAIT_RS;
                    clear_cnt  = 1'b1;
                end
            end
            WAIT_RS: begin
                if (rs_q) state_next = RUN;
            end
            RUN: begin
                if (accept && last_pixel) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Completed-frame counter, bumped as the last pixel is consumed so it
    // already reads the new value during the frame_done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    frame_count <= '0;
        else if (accept && last_pixel) frame_count <= frame_count + 16'd1;
    end

    raster_counter #(
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .CORE_SIZE (CORE_SIZE),
        .X_W       (X_W),
        .Y_W       (Y_W),
        .IDX_W     (IDX_W),
        .CORE_W    (CORE_W)
    ) u_raster (
        .clk         (clk),
        .rst         (reset),
        .clear       (clear_cnt),
        .advance     (accept),
        .x           (x),
        .y           (y),
        .pixel_index (pixel_index),
        .core_id     (core_id),
        .last_pixel  (last_pixel)
    );

endmodule

// File: doc/ray_thread_generator.md
Name: ray_thread_generator

Overview:
Upstream feeder of the Surface stage. On a frame-start strobe it scans the frame in raster order and emits one primary-ray thread per accepted cycle, carrying the pixel coordinate, the linear pixel index and a round-robin ray-core id. It throttles on the downstream input FIFO-full signal and raises a one-cycle frame-done pulse after the last pixel is accepted. Surface builds the primary ray from RenderState using these fields.

Parameters:
WIDTH, 160, frame width in pixels (>=2)
HEIGHT, 120, frame height in pixels (>=2)
CORE_SIZE, 4, number of ray cores (matches RAY_CORE_SIZE); core id wraps modulo this
X_W, $clog2(WIDTH), x coordinate width (derived)
Y_W, $clog2(HEIGHT), y coordinate width (derived)
IDX_W, $clog2(WIDTH*HEIGHT), pixel index width (derived)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
strobe  in  1  frame-start request, sampled only in IDLE
rs_valid  in  1  RenderState output valid; must be high before emission starts
output_fifo_full  in  1  downstream cannot accept; holds current thread
valid  out  1  thread fields are valid
x  out  X_W  pixel column
y  out  Y_W  pixel row
pixel_index  out  IDX_W  y*WIDTH+x
core_id  out  $clog2(CORE_SIZE)  target ray core
busy  out  1  high in WAIT_RS and RUN
frame_done  out  1  one-cycle pulse after last pixel is accepted
frame_count  out  16  completed frames, wraps at 65535->0

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE; valid, busy, frame_done=0; x, y, pixel_index, core_id=0; frame_count=0. Any partial frame is dropped. No thread is emitted until the next strobe.
- Accept = valid && !output_fifo_full, evaluated in the same cycle.
- IDLE: valid=0. If strobe=1, go to WAIT_RS, with x=y=pixel_index=core_id=0.
- WAIT_RS: valid=0. When rs_valid=1, go to RUN; valid goes high the following cycle.
- RUN: valid=1. All outputs are registered and stay stable while output_fifo_full=1.
- On each accept:
  - x+1; if x==WIDTH-1, then x=0 and y+1.
  - pixel_index+1.
  - core_id+1, wrapping at CORE_SIZE-1 to 0.
- Last pixel: on accept with x==WIDTH-1 and y==HEIGHT-1, go to DONE and drop valid next cycle. Exactly WIDTH*HEIGHT threads are accepted per frame.
- Throughput: one thread per cycle when output_fifo_full=0. Latency from strobe to first valid is 2 cycles when rs_valid is already high.
- DONE: frame_done=1 for exactly one cycle, frame_count+1, go to IDLE. A strobe in this cycle is ignored.
- strobe in WAIT_RS, RUN or DONE is ignored, not queued.
- rs_valid dropping during RUN does not stall emission. RenderState is frame-static.
- output_fifo_full asserted in WAIT_RS or IDLE has no effect.
- Width rules:
  - counters are unsigned and compared against WIDTH-1 and HEIGHT-1, never a power-of-two rollover;
  - pixel_index is never computed with a multiplier; it is incremented.

Decomposition:
- Shared types package:
  - ThreadCoord struct {x, y, pixel_index, core_id}, so Surface's input_data can absorb it;
  - TG state enum {IDLE, WAIT_RS, RUN, DONE};
  - default WIDTH/HEIGHT constants alongside RAY_CORE_SIZE.
- One sub-module is natural: raster_counter (x/y/index counter with advance input and last-pixel flag). The FSM and handshake stay in the top.

Test Plan:
- WIDTH=4, HEIGHT=2, CORE_SIZE=4, rs_valid=1, full=0, strobe pulse -> valid from cycle 2 for 8 consecutive cycles. (x,y) runs (0,0)…(3,0),(0,1)…(3,1); pixel_index 0..7; core_id 0,1,2,3,0,1,2,3; frame_done one cycle after index 7; frame_count=1.
- Hold output_fifo_full=1 for 5 cycles at pixel_index=3 -> outputs frozen at x=3, y=0, core_id=3; resumes with index 4 on release; total accepts still 8.
- strobe with rs_valid=0 for 10 cycles, then 1 -> busy=1, valid=0 throughout the wait; first thread (0,0) two cycles after rs_valid rises.
- Extra strobe pulses during RUN and in the DONE cycle -> frame unaffected, no second frame starts, frame_count=1.
- Assert reset at pixel_index=5 -> same cycle valid=0 and counters=0; new strobe restarts at (0,0), core_id=0, frame_count=0.
- Run 2 back-to-back frames with CORE_SIZE=3 -> core_id restarts at 0 each frame; frame_count=2; exactly 16 accepts.
